mult_control: RTL and testbench

//  Control FSM for the shift-add signed multiplier.

---
 rtl/mult_control.sv | 76 +++++++
 tb/tb_mult_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// Sequencer for the shift-add signed multiplier: steps the X:A:B chain through
// clear, N add/shift iterations (subtracting on the sign bit) and a hold state.
module mult_control #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             M,
  output logic             Clr_XA,
  output logic             Ld_B,
  output logic             Ld_XA,
  output logic             Fn,
  output logic             Shift_EN,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_iter;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_iter == LAST_ITER);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!ClearA_LoadB && Run) w_next = S_CLR;
      S_CLR:   w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_HOLD : S_ADD;
      S_HOLD:  if (!Run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Done fires on the SHIFT->HOLD transition only, so it is a single pulse.
      r_done  <= (r_state == S_SHIFT) && w_last;
      if (r_state == S_CLR)
        r_iter <= '0;
      else if (r_state == S_SHIFT && !w_last)
        r_iter <= r_iter + 1'b1;
    end
  end

  // Gating with Reset_n keeps the Mealy IDLE outputs quiet while reset is held.
  assign Clr_XA   = Reset_n && (((r_state == S_IDLE) && ClearA_LoadB) || (r_state == S_CLR));
  assign Ld_B     = Reset_n && (r_state == S_IDLE) && ClearA_LoadB;
  assign Ld_XA    = Reset_n && (r_state == S_ADD) && M;
  assign Fn       = Reset_n && (r_state == S_ADD) && w_last;
  assign Shift_EN = Reset_n && (r_state == S_SHIFT);
  assign Busy     = Reset_n && ((r_state == S_CLR) || (r_state == S_ADD) || (r_state == S_SHIFT));
  assign Done     = r_done;
  assign Iter     = r_iter;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: cycle-count model of the multiply sequence plus
// directed scenarios with hand-computed pulse counts and latencies.
module tb_mult_control;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Run = 1'b0;
  logic             ClearA_LoadB = 1'b0;
  logic             M = 1'b0;
  logic             Clr_XA, Ld_B, Ld_XA, Fn, Shift_EN, Busy, Done;
  logic [CNT_W-1:0] Iter;

  mult_control #(.N(N), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Ld_XA(Ld_XA), .Fn(Fn), .Shift_EN(Shift_EN),
    .Busy(Busy), .Done(Done), .Iter(Iter)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a multiply is "cycles since start" k = 1..2N+1.
  // k=1 clear, even k = add of iteration (k-2)/2, odd k>=3 = shift of (k-3)/2.
  int m_phase = 0;   // 0 idle, 1 multiplying, 2 holding result
  int m_k     = 0;
  int m_iter  = 0;   // iteration index shown outside the add/shift window
  int m_done  = 0;
  int m_start = 0;
  int cyc     = 0;
  logic [7:0] mpat = 8'h00;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_phase = 0; m_k = 0; m_iter = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_phase)
        0: if (!ClearA_LoadB && Run) begin m_phase = 1; m_k = 1; m_start = cyc; end
        1: if (m_k == 2*N + 1) begin m_phase = 2; m_done = 1; m_iter = N - 1; end
           else m_k++;
        default: if (!Run) m_phase = 0;
      endcase
      cyc++;
    end
  end

  int cnt_shift, cnt_ldxa, cnt_busy, cnt_done, done_cyc, clr_cyc;
  int ldxa_mask, fn_mask;

  task automatic clr_counts();
    cnt_shift = 0; cnt_ldxa = 0; cnt_busy = 0; cnt_done = 0;
    done_cyc = -1; clr_cyc = -1; ldxa_mask = 0; fn_mask = 0;
  endtask

  always @(negedge Clk) begin
    logic e_add, e_sh, e_idle;
    int   e_iter;
    e_idle = Reset_n && (m_phase == 0);
    e_add  = Reset_n && (m_phase == 1) && (m_k >= 2) && (m_k % 2 == 0);
    e_sh   = Reset_n && (m_phase == 1) && (m_k >= 3) && (m_k % 2 == 1);
    e_iter = (m_phase == 1 && m_k >= 2) ? (m_k - 2) / 2 : m_iter;
    chk("Clr_XA",   32'(Clr_XA),   32'((e_idle && ClearA_LoadB) || (Reset_n && m_phase == 1 && m_k == 1)));
    chk("Ld_B",     32'(Ld_B),     32'(e_idle && ClearA_LoadB));
    chk("Ld_XA",    32'(Ld_XA),    32'(e_add && M));
    chk("Fn",       32'(Fn),       32'(e_add && (e_iter == N - 1)));
    chk("Shift_EN", 32'(Shift_EN), 32'(e_sh));
    chk("Busy",     32'(Busy),     32'(Reset_n && m_phase == 1));
    chk("Done",     32'(Done),     32'(m_done));
    chk("Iter",     32'(Iter),     32'(e_iter));
    if (Reset_n) begin
      if (Shift_EN) cnt_shift++;
      if (Ld_XA) begin cnt_ldxa++; ldxa_mask |= (1 << Iter); end
      if (Fn) fn_mask |= (1 << Iter);
      if (Busy) cnt_busy++;
      if (Done) begin cnt_done++; done_cyc = cyc; end
      if (Clr_XA && Busy && clr_cyc < 0) clr_cyc = cyc;
    end
  end

  // Advance one cycle; M follows the multiplier bit the model says B[0] holds.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (m_phase == 1 && m_k >= 2 && m_k % 2 == 0) M = mpat[(m_k - 2) / 2];
    else M = 1'($urandom % 2);
  endtask

  task automatic wait_hold(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_phase == 2) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_run();
    clr_counts();
    Run = 1'b1;
    tick();
    Run = 1'b0;
  endtask

  initial begin
    clr_counts();
    ClearA_LoadB = 1'b1;
    repeat (2) tick();
    chk("rst_clr_gated", 32'(Clr_XA), 32'd0);
    chk("rst_ldb_gated", 32'(Ld_B), 32'd0);
    chk("rst_iter", 32'(Iter), 32'd0);
    ClearA_LoadB = 1'b0;
    Reset_n = 1'b1;
    tick();

    // B = 3: multiplier bits 1,1,0,0,0,0,0,0
    mpat = 8'h03;
    pulse_run();
    wait_hold("t2");
    tick();
    chk("t2_clr_lat",   32'(clr_cyc - m_start), 32'd1);
    chk("t2_done_lat",  32'(done_cyc - m_start), 32'd18);
    chk("t2_shifts",    32'(cnt_shift), 32'd8);
    chk("t2_ldxa_mask", 32'(ldxa_mask), 32'h03);
    chk("t2_done_cnt",  32'(cnt_done), 32'd1);

    // B = -1: every bit set, subtract only on the last add
    mpat = 8'hFF;
    pulse_run();
    wait_hold("t3");
    tick();
    chk("t3_ldxa_cnt", 32'(cnt_ldxa), 32'd8);
    chk("t3_fn_mask",  32'(fn_mask), 32'h80);
    chk("t3_busy_cnt", 32'(cnt_busy), 32'd17);

    // Run held for 40 cycles: one product, then parked in HOLD
    mpat = 8'hA5;
    clr_counts();
    Run = 1'b1;
    repeat (40) tick();
    chk("t4_done_cnt", 32'(cnt_done), 32'd1);
    chk("t4_busy_cnt", 32'(cnt_busy), 32'd17);
    chk("t4_ldxa_cnt", 32'(cnt_ldxa), 32'd4);
    Run = 1'b0;
    ClearA_LoadB = 1'b1;
    #1 chk("t4_hold_ignores_clab", 32'(Clr_XA), 32'd0);
    tick();
    #1;
    chk("t4_idle_clr", 32'(Clr_XA), 32'd1);
    chk("t4_idle_ldb", 32'(Ld_B), 32'd1);
    ClearA_LoadB = 1'b0;
    tick();

    // ClearA_LoadB raised mid-multiply has no effect
    mpat = 8'h5A;
    pulse_run();
    for (int i = 0; i < 10 && m_k != 5; i++) tick();
    ClearA_LoadB = 1'b1;
    repeat (4) tick();
    ClearA_LoadB = 1'b0;
    wait_hold("t5");
    tick();
    chk("t5_done_lat", 32'(done_cyc - m_start), 32'd18);
    chk("t5_shifts",   32'(cnt_shift), 32'd8);
    chk("t5_ldxa_mask", 32'(ldxa_mask), 32'h5A);

    // Run and ClearA_LoadB together in IDLE: load wins until it drops
    clr_counts();
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    repeat (3) begin
      tick();
      #1;
      chk("t6_clr", 32'(Clr_XA), 32'd1);
      chk("t6_ldb", 32'(Ld_B), 32'd1);
      chk("t6_busy", 32'(Busy), 32'd0);
    end
    ClearA_LoadB = 1'b0;
    tick();
    #1;
    chk("t6_clr_state", 32'(Clr_XA), 32'd1);
    chk("t6_clr_ldb",   32'(Ld_B), 32'd0);
    chk("t6_clr_busy",  32'(Busy), 32'd1);
    Run = 1'b0;
    wait_hold("t6");
    tick();

    // Asynchronous reset during the SHIFT of iteration 3
    mpat = 8'h0F;
    pulse_run();
    for (int i = 0; i < 20 && m_k != 9; i++) tick();
    chk("t1_in_shift", 32'(Shift_EN), 32'd1);
    chk("t1_iter3", 32'(Iter), 32'd3);
    #2 Reset_n = 1'b0;
    #1;
    chk("t1_shift_off", 32'(Shift_EN), 32'd0);
    chk("t1_busy_off",  32'(Busy), 32'd0);
    chk("t1_iter0",     32'(Iter), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    #1;
    chk("t1_idle_busy", 32'(Busy), 32'd0);
    chk("t1_idle_shift", 32'(Shift_EN), 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
